// File: rtl/deser_frame_arbiter_if.sv
// Handshake bundle between sample-stream requesters, the frame arbiter and the shared deserializer.
// master = requesters/deserializer side, slave = arbiter side.
interface deser_frame_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int BIT_WIDTH = 32
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]           req_val;
  logic [N_REQ-1:0]           req_rdy;
  logic [N_REQ*BIT_WIDTH-1:0] req_msg;
  logic                       des_recv_val;
  logic                       des_recv_rdy;
  logic [BIT_WIDTH-1:0]       des_recv_msg;
  logic                       des_send_val;
  logic                       des_send_rdy;
  logic [ID_W-1:0]            frame_id;
  logic                       frame_id_val;

  modport master (
    output req_val, req_msg, des_recv_rdy, des_send_val, des_send_rdy,
    input  req_rdy, des_recv_val, des_recv_msg, frame_id, frame_id_val
  );

  modport slave (
    input  req_val, req_msg, des_recv_rdy, des_send_val, des_send_rdy,
    output req_rdy, des_recv_val, des_recv_msg, frame_id, frame_id_val
  );
endinterface

// File: rtl/deser_frame_arbiter.sv
// Round-robin arbiter that lends one shared deserializer to N_REQ sample streams, one whole
// frame at a time, and tags the drained frame with its owner's index.
module deser_frame_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  deser_frame_arbiter_if.slave  bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(N_SAMPLES) + 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t               state_reg, state_next;
  logic [ID_W-1:0]      ptr_reg, ptr_next;
  logic [ID_W-1:0]      grant_reg, grant_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [ID_W-1:0]      pick;
  logic                 found;
  logic                 owner_val;
  logic                 transfer;
  logic [N_REQ-1:0]     grant_hot;
  logic [BIT_WIDTH-1:0] msg_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign msg_arr[gi]   = bus.req_msg[gi*BIT_WIDTH +: BIT_WIDTH];
    assign grant_hot[gi] = (grant_reg == ID_W'(gi));
  end

  // Round-robin search: requesters at or above ptr win first, then wrap to the bottom.
  always_comb begin
    pick  = ptr_reg;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req_val[i] && (ID_W'(i) >= ptr_reg)) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req_val[i]) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  assign owner_val = |(bus.req_val & grant_hot);
  assign transfer  = (state_reg == BURST) && owner_val && bus.des_recv_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    ptr_next          = ptr_reg;
    grant_next        = grant_reg;
    count_next        = count_reg;
    bus.req_rdy       = '0;
    bus.des_recv_val  = 1'b0;
    bus.des_recv_msg  = '0;
    bus.frame_id      = '0;
    bus.frame_id_val  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          state_next = BURST;
        end
      end
      BURST: begin
        bus.req_rdy      = grant_hot & {N_REQ{bus.des_recv_rdy}};
        bus.des_recv_val = owner_val;
        bus.des_recv_msg = msg_arr[grant_reg];
        bus.frame_id     = grant_reg;
        if (transfer) begin
          if (count_reg == CNT_W'(N_SAMPLES - 1)) begin
            count_next = '0;
            state_next = DRAIN;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        bus.frame_id     = grant_reg;
        bus.frame_id_val = 1'b1;
        // Re-arbitrate only once the deserializer has handed the frame downstream.
        if (bus.des_send_val && bus.des_send_rdy) begin
          state_next = IDLE;
          ptr_next   = (grant_reg == ID_W'(N_REQ - 1)) ? '0 : grant_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_deser_frame_arbiter.sv
// Randomized bench for deser_frame_arbiter: scenario tasks compare the DUT with a
// transaction-level round-robin frame model kept here.
module tb_deser_frame_arbiter;
  localparam int N_REQ     = 4;
  localparam int N_SAMPLES = 8;
  localparam int BIT_WIDTH = 32;
  localparam int ID_W      = 2;
  localparam int DEPTH     = 256;
  localparam int RR_FRAMES = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  deser_frame_arbiter_if #(.N_REQ(N_REQ), .BIT_WIDTH(BIT_WIDTH)) bus ();

  deser_frame_arbiter #(.N_REQ(N_REQ), .N_SAMPLES(N_SAMPLES), .BIT_WIDTH(BIT_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [BIT_WIDTH-1:0] pat [N_REQ][DEPTH];
  int                   sent [N_REQ];
  logic [N_REQ-1:0]     val_mask;
  logic                 recv_rdy, send_val, send_rdy;

  logic [N_REQ-1:0]     o_req_rdy;
  logic                 o_recv_val;
  logic [BIT_WIDTH-1:0] o_recv_msg;
  logic [ID_W-1:0]      o_fid;
  logic                 o_fid_val;

  int                   xfer_src[$];
  logic [BIT_WIDTH-1:0] xfer_data[$];

  // One clock: apply inputs, sample outputs mid-cycle, log handshakes, advance past the edge.
  task automatic step();
    int src;
    for (int i = 0; i < N_REQ; i++) bus.req_msg[i*BIT_WIDTH +: BIT_WIDTH] = pat[i][sent[i]];
    bus.req_val      = val_mask;
    bus.des_recv_rdy = recv_rdy;
    bus.des_send_val = send_val;
    bus.des_send_rdy = send_rdy;
    #1;
    o_req_rdy  = bus.req_rdy;
    o_recv_val = bus.des_recv_val;
    o_recv_msg = bus.des_recv_msg;
    o_fid      = bus.frame_id;
    o_fid_val  = bus.frame_id_val;
    src = -1;
    for (int i = 0; i < N_REQ; i++) if (bus.req_val[i] && bus.req_rdy[i]) src = i;
    if (o_recv_val && recv_rdy) begin
      xfer_src.push_back(src);
      xfer_data.push_back(o_recv_msg);
    end
    for (int i = 0; i < N_REQ; i++)
      if (bus.req_val[i] && bus.req_rdy[i]) sent[i] = (sent[i] + 1) % DEPTH;
    $display("cyc val=%b rdy_in=%b send=%b%b | req_rdy=%b recv_val=%b msg=%h fid=%0d fid_val=%b",
             val_mask, recv_rdy, send_val, send_rdy, o_req_rdy, o_recv_val, o_recv_msg, o_fid, o_fid_val);
    @(posedge clk);
    #1;
  endtask

  // Reference rule: first valid requester at or after ptr, wrapping modulo N_REQ.
  function automatic int rr_pick(logic [N_REQ-1:0] mask, int ptr);
    for (int k = 0; k < N_REQ; k++)
      if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; val_mask = '0; recv_rdy = 1'b0; send_val = 1'b0; send_rdy = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (o_req_rdy !== '0) begin failures++; $display("FAIL reset_req_rdy got=%b required=0", o_req_rdy); end
    checks++; if (o_recv_val !== 1'b0) begin failures++; $display("FAIL reset_recv_val got=%b required=0", o_recv_val); end
    checks++; if (o_recv_msg !== '0) begin failures++; $display("FAIL reset_recv_msg got=%h required=0", o_recv_msg); end
    checks++; if (o_fid !== '0) begin failures++; $display("FAIL reset_fid got=%0d required=0", o_fid); end
    checks++; if (o_fid_val !== 1'b0) begin failures++; $display("FAIL reset_fid_val got=%b required=0", o_fid_val); end
  endtask

  task automatic test_single_req();
    for (int k = 0; k < N_SAMPLES; k++) pat[2][k] = BIT_WIDTH'(32'h10 + k);
    sent[2] = 0;
    val_mask = 4'b0100; recv_rdy = 1'b1; send_val = 1'b1; send_rdy = 1'b1;
    step();
    checks++; if (o_req_rdy !== '0 || o_recv_val !== 1'b0) begin failures++; $display("FAIL single_arb_cycle got rdy=%b val=%b required 0/0", o_req_rdy, o_recv_val); end
    for (int k = 0; k < N_SAMPLES; k++) begin
      step();
      checks++; if (o_req_rdy !== 4'b0100) begin failures++; $display("FAIL single_req_rdy k=%0d got=%b required=0100", k, o_req_rdy); end
      checks++; if (o_recv_msg !== BIT_WIDTH'(32'h10 + k) || o_recv_val !== 1'b1) begin failures++; $display("FAIL single_msg k=%0d got=%h/%b required=%h/1", k, o_recv_msg, o_recv_val, 32'h10 + k); end
      checks++; if (o_fid !== 2'd2) begin failures++; $display("FAIL single_burst_fid k=%0d got=%0d required=2", k, o_fid); end
    end
    step();
    checks++; if (o_fid_val !== 1'b1 || o_fid !== 2'd2) begin failures++; $display("FAIL single_drain got fid=%0d val=%b required 2/1", o_fid, o_fid_val); end
    checks++; if (o_req_rdy !== '0 || o_recv_val !== 1'b0) begin failures++; $display("FAIL single_drain_quiet got rdy=%b val=%b required 0/0", o_req_rdy, o_recv_val); end
    // ptr should now be 3, so req 3 beats req 0.
    val_mask = 4'b1001;
    step();
    checks++; if (o_fid_val !== 1'b0 || o_req_rdy !== '0) begin failures++; $display("FAIL single_back_idle got fid_val=%b rdy=%b required 0/0", o_fid_val, o_req_rdy); end
    step();
    checks++; if (o_fid !== 2'd3 || o_req_rdy !== 4'b1000) begin failures++; $display("FAIL single_next_ptr got fid=%0d rdy=%b required 3/1000", o_fid, o_req_rdy); end
  endtask

  task automatic test_round_robin();
    int owners[RR_FRAMES];
    int base[N_REQ];
    int ptr, done, cyc, cur, o;
    logic [N_REQ-1:0] exp_rdy;
    do_reset();
    xfer_src.delete(); xfer_data.delete();
    val_mask = '1; send_val = 1'b1;
    ptr = 0;
    for (int f = 0; f < RR_FRAMES; f++) begin
      owners[f] = rr_pick(val_mask, ptr);
      ptr = (owners[f] + 1) % N_REQ;
    end
    for (int i = 0; i < N_REQ; i++) base[i] = sent[i];
    done = 0; cyc = 0;
    while (done < RR_FRAMES && cyc < 600) begin
      cur = owners[done];
      recv_rdy = 1'($urandom_range(0, 1));
      send_rdy = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
      checks++; if ($countones(o_req_rdy) > 1) begin failures++; $display("FAIL rr_onehot cyc=%0d got=%b required at most one bit", cyc, o_req_rdy); end
      if (o_recv_val) begin
        exp_rdy = '0; exp_rdy[cur] = recv_rdy;
        checks++; if (o_req_rdy !== exp_rdy) begin failures++; $display("FAIL rr_req_rdy cyc=%0d got=%b required=%b", cyc, o_req_rdy, exp_rdy); end
        checks++; if (o_fid !== ID_W'(cur)) begin failures++; $display("FAIL rr_fid cyc=%0d got=%0d required=%0d", cyc, o_fid, cur); end
      end
      if (o_fid_val && send_rdy) done++;
    end
    checks++; if (done != RR_FRAMES) begin failures++; $display("FAIL rr_timeout frames got=%0d required=%0d", done, RR_FRAMES); end
    checks++; if (xfer_data.size() != RR_FRAMES*N_SAMPLES) begin failures++; $display("FAIL rr_xfer_count got=%0d required=%0d", xfer_data.size(), RR_FRAMES*N_SAMPLES); end
    for (int f = 0; f < RR_FRAMES; f++) begin
      o = owners[f];
      for (int k = 0; k < N_SAMPLES; k++) begin
        if (f*N_SAMPLES + k < xfer_data.size()) begin
          checks++; if (xfer_src[f*N_SAMPLES+k] != o) begin failures++; $display("FAIL rr_src frame=%0d k=%0d got=%0d required=%0d", f, k, xfer_src[f*N_SAMPLES+k], o); end
          checks++; if (xfer_data[f*N_SAMPLES+k] !== pat[o][base[o]]) begin failures++; $display("FAIL rr_data frame=%0d k=%0d got=%h required=%h", f, k, xfer_data[f*N_SAMPLES+k], pat[o][base[o]]); end
        end
        base[o] = (base[o] + 1) % DEPTH;
      end
    end
  endtask

  task automatic test_owner_stall();
    int b;
    xfer_src.delete(); xfer_data.delete();
    val_mask = 4'b1011; recv_rdy = 1'b1; send_val = 1'b1; send_rdy = 1'b1;
    b = sent[1];
    step();
    for (int k = 0; k < 11; k++) begin
      val_mask = (k >= 4 && k < 7) ? 4'b1001 : 4'b1011;
      step();
      checks++; if (o_req_rdy !== 4'b0010 || o_fid !== 2'd1) begin failures++; $display("FAIL stall_grant k=%0d got rdy=%b fid=%0d required 0010/1", k, o_req_rdy, o_fid); end
      checks++; if (o_recv_val !== val_mask[1]) begin failures++; $display("FAIL stall_recv_val k=%0d got=%b required=%b", k, o_recv_val, val_mask[1]); end
    end
    step();
    checks++; if (o_fid_val !== 1'b1 || o_fid !== 2'd1) begin failures++; $display("FAIL stall_drain got fid=%0d val=%b required 1/1", o_fid, o_fid_val); end
    checks++; if (xfer_data.size() != N_SAMPLES) begin failures++; $display("FAIL stall_count got=%0d required=%0d", xfer_data.size(), N_SAMPLES); end
    for (int k = 0; k < xfer_data.size(); k++) begin
      checks++; if (xfer_src[k] != 1 || xfer_data[k] !== pat[1][(b + k) % DEPTH]) begin failures++; $display("FAIL stall_sample k=%0d got src=%0d data=%h required src=1 data=%h", k, xfer_src[k], xfer_data[k], pat[1][(b + k) % DEPTH]); end
    end
  endtask

  task automatic test_rdy_toggle();
    val_mask = '1; send_val = 1'b1; send_rdy = 1'b0; recv_rdy = 1'b0;
    step();
    for (int c = 0; c < 2*N_SAMPLES - 1; c++) begin
      recv_rdy = (c % 2 == 0);
      step();
      checks++; if (o_req_rdy !== (recv_rdy ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL toggle_mirror c=%0d got=%b required=%b", c, o_req_rdy, recv_rdy ? 4'b0100 : 4'b0000); end
      checks++; if (o_recv_val !== 1'b1 || o_fid_val !== 1'b0) begin failures++; $display("FAIL toggle_in_burst c=%0d got val=%b fid_val=%b required 1/0", c, o_recv_val, o_fid_val); end
    end
  endtask

  task automatic test_drain_hold();
    send_val = 1'b1; send_rdy = 1'b0; recv_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (o_fid_val !== 1'b1 || o_fid !== 2'd2) begin failures++; $display("FAIL hold_fid c=%0d got fid=%0d val=%b required 2/1", c, o_fid, o_fid_val); end
      checks++; if (o_req_rdy !== '0 || o_recv_val !== 1'b0) begin failures++; $display("FAIL hold_quiet c=%0d got rdy=%b val=%b required 0/0", c, o_req_rdy, o_recv_val); end
    end
    send_rdy = 1'b1;
    step();
    checks++; if (o_fid_val !== 1'b1) begin failures++; $display("FAIL hold_handshake_cycle got fid_val=%b required 1", o_fid_val); end
    val_mask = '0;
    step();
    checks++; if (o_fid_val !== 1'b0 || o_fid !== '0 || o_req_rdy !== '0) begin failures++; $display("FAIL hold_exit got fid_val=%b fid=%0d rdy=%b required 0/0/0", o_fid_val, o_fid, o_req_rdy); end
  endtask

  task automatic test_reset_abort();
    val_mask = 4'b1000; recv_rdy = 1'b1; send_val = 1'b1; send_rdy = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (o_req_rdy !== 4'b1000) begin failures++; $display("FAIL abort_pre k=%0d got=%b required=1000", k, o_req_rdy); end
    end
    reset = 1'b1; recv_rdy = 1'b0;
    step();
    reset = 1'b0; val_mask = '0; recv_rdy = 1'b1;
    step();
    checks++; if (o_req_rdy !== '0 || o_recv_val !== 1'b0 || o_recv_msg !== '0) begin failures++; $display("FAIL abort_idle got rdy=%b val=%b msg=%h required 0/0/0", o_req_rdy, o_recv_val, o_recv_msg); end
    checks++; if (o_fid !== '0 || o_fid_val !== 1'b0) begin failures++; $display("FAIL abort_fid got fid=%0d val=%b required 0/0", o_fid, o_fid_val); end
    val_mask = 4'b1000;
    step();
    for (int k = 0; k < N_SAMPLES; k++) begin
      step();
      checks++; if (o_recv_val !== 1'b1 || o_req_rdy !== 4'b1000) begin failures++; $display("FAIL abort_fresh k=%0d got val=%b rdy=%b required 1/1000", k, o_recv_val, o_req_rdy); end
    end
    step();
    checks++; if (o_fid_val !== 1'b1 || o_fid !== 2'd3) begin failures++; $display("FAIL abort_drain got fid=%0d val=%b required 3/1", o_fid, o_fid_val); end
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      sent[i] = 0;
      for (int k = 0; k < DEPTH; k++) pat[i][k] = BIT_WIDTH'($urandom);
    end
    val_mask = '0; recv_rdy = 1'b0; send_val = 1'b0; send_rdy = 1'b0;
    bus.req_val = '0; bus.req_msg = '0; bus.des_recv_rdy = 1'b0;
    bus.des_send_val = 1'b0; bus.des_send_rdy = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_req();
    test_round_robin();
    test_owner_stall();
    test_rdy_toggle();
    test_drain_hold();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
